// File: rtl/cpu_defs.sv
// Shared definitions for the five-stage MIPS core: widths, stall-vector indices
// and the per-cycle action decode used by the pipeline boundary registers.
package cpu_defs;

  localparam int STALL_W   = 6;
  localparam int STAGE_PC  = 0;
  localparam int STAGE_IF  = 1;
  localparam int STAGE_ID  = 2;
  localparam int STAGE_EX  = 3;
  localparam int STAGE_MEM = 4;
  localparam int STAGE_WB  = 5;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    OP_ADVANCE = 2'd0,
    OP_BUBBLE  = 2'd1,
    OP_HOLD    = 2'd2,
    OP_FLUSH   = 2'd3
  } stage_op_e;

  // Flush beats every stall combination; a stalled stage with a free
  // downstream stage emits a bubble, otherwise it holds.
  function automatic stage_op_e stage_op(input logic flush,
                                         input logic stall_here,
                                         input logic stall_next);
    if (flush)            return OP_FLUSH;
    else if (!stall_here) return OP_ADVANCE;
    else if (!stall_next) return OP_BUBBLE;
    else                  return OP_HOLD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
// Latency 1 cycle from inc to q; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary register with valid gating, flush, multi-cycle temporary
// loop-back to EX and a saturating bubble counter. Latency 1 cycle.
module ex_mem_stage #(
  parameter int DATA_W  = cpu_defs::DATA_W,
  parameter int RADDR_W = cpu_defs::RADDR_W,
  parameter int TMP_W   = 64,
  parameter int CNT_W   = 2,
  parameter int STALL_W = cpu_defs::STALL_W,
  parameter int STAGE   = cpu_defs::STAGE_EX,
  parameter int BCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               ex_valid,
  input  logic [RADDR_W-1:0] ex_wd,
  input  logic               ex_wreg,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic               ex_whilo,
  input  logic [DATA_W-1:0]  ex_hi,
  input  logic [DATA_W-1:0]  ex_lo,
  input  logic [TMP_W-1:0]   tmp_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [TMP_W-1:0]   tmp_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               mem_valid,
  output logic [RADDR_W-1:0] mem_wd,
  output logic               mem_wreg,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_whilo,
  output logic [DATA_W-1:0]  mem_hi,
  output logic [DATA_W-1:0]  mem_lo,
  output logic [BCNT_W-1:0]  bubble_cnt
);

  import cpu_defs::*;

  stage_op_e op;

  logic               valid_q, valid_d;
  logic [RADDR_W-1:0] wd_q, wd_d;
  logic               wreg_q, wreg_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               whilo_q, whilo_d;
  logic [DATA_W-1:0]  hi_q, hi_d;
  logic [DATA_W-1:0]  lo_q, lo_d;
  logic [TMP_W-1:0]   tmp_q, tmp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    op      = stage_op(flush, stall[STAGE], stall[STAGE+1]);
    valid_d = valid_q;
    wd_d    = wd_q;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    whilo_d = whilo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    tmp_d   = tmp_q;
    cnt_d   = cnt_q;
    case (op)
      OP_ADVANCE: begin
        valid_d = ex_valid;
        wd_d    = ex_wd;
        wreg_d  = ex_wreg & ex_valid;
        wdata_d = ex_wdata;
        whilo_d = ex_whilo & ex_valid;
        hi_d    = ex_hi;
        lo_d    = ex_lo;
        tmp_d   = '0;
        cnt_d   = '0;
      end
      OP_BUBBLE, OP_FLUSH: begin
        valid_d = 1'b0;
        wd_d    = '0;
        wreg_d  = 1'b0;
        wdata_d = ZERO_WORD[DATA_W-1:0];
        whilo_d = 1'b0;
        hi_d    = '0;
        lo_d    = '0;
        // A bubble keeps the EX multi-cycle op alive; a flush restarts it.
        tmp_d   = (op == OP_BUBBLE) ? tmp_i : '0;
        cnt_d   = (op == OP_BUBBLE) ? cnt_i : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
      whilo_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      tmp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      wd_q    <= wd_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      whilo_q <= whilo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      tmp_q   <= tmp_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(.W(BCNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (op == OP_BUBBLE),
    .q   (bubble_cnt)
  );

  assign mem_valid = valid_q;
  assign mem_wd    = wd_q;
  assign mem_wreg  = wreg_q;
  assign mem_wdata = wdata_q;
  assign mem_whilo = whilo_q;
  assign mem_hi    = hi_q;
  assign mem_lo    = lo_q;
  assign tmp_o     = tmp_q;
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table plus reset/saturation sequences.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush, ex_valid, ex_wreg, ex_whilo;
  logic [4:0]  ex_wd;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [63:0] tmp_i;
  logic [1:0]  cnt_i;

  logic [63:0] tmp_o, s_tmp_o;
  logic [1:0]  cnt_o, s_cnt_o;
  logic        mem_valid, mem_wreg, mem_whilo, s_mem_valid, s_mem_wreg, s_mem_whilo;
  logic [4:0]  mem_wd, s_mem_wd;
  logic [31:0] mem_wdata, mem_hi, mem_lo, s_mem_wdata, s_mem_hi, s_mem_lo;
  logic [15:0] bubble_cnt;
  logic [1:0]  s_bubble_cnt;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .tmp_i(tmp_i), .cnt_i(cnt_i),
    .tmp_o(tmp_o), .cnt_o(cnt_o), .mem_valid(mem_valid), .mem_wd(mem_wd),
    .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .bubble_cnt(bubble_cnt)
  );

  ex_mem_stage #(.BCNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .ex_valid(ex_valid),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .tmp_i(tmp_i), .cnt_i(cnt_i),
    .tmp_o(s_tmp_o), .cnt_o(s_cnt_o), .mem_valid(s_mem_valid), .mem_wd(s_mem_wd),
    .mem_wreg(s_mem_wreg), .mem_wdata(s_mem_wdata), .mem_whilo(s_mem_whilo),
    .mem_hi(s_mem_hi), .mem_lo(s_mem_lo), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic [5:0]  stall;
    logic        flush, valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic [63:0] tmp;
    logic [1:0]  cnt;
    logic        e_valid;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic        e_whilo;
    logic [31:0] e_hi, e_lo;
    logic [63:0] e_tmp;
    logic [1:0]  e_cnt;
    logic [15:0] e_bcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
      input logic [5:0] st, input logic fl, input logic va, input logic [4:0] wd,
      input logic wr, input logic [31:0] wdat, input logic wh, input logic [31:0] hi,
      input logic [31:0] lo, input logic [63:0] tm, input logic [1:0] cn,
      input logic eva, input logic [4:0] ewd, input logic ewr, input logic [31:0] ewdat,
      input logic ewh, input logic [31:0] ehi, input logic [31:0] elo,
      input logic [63:0] etm, input logic [1:0] ecn, input logic [15:0] eb);
    vec_t v;
    v.stall = st; v.flush = fl; v.valid = va; v.wd = wd; v.wreg = wr; v.wdata = wdat;
    v.whilo = wh; v.hi = hi; v.lo = lo; v.tmp = tm; v.cnt = cn;
    v.e_valid = eva; v.e_wd = ewd; v.e_wreg = ewr; v.e_wdata = ewdat; v.e_whilo = ewh;
    v.e_hi = ehi; v.e_lo = elo; v.e_tmp = etm; v.e_cnt = ecn; v.e_bcnt = eb;
    return v;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    stall = v.stall; flush = v.flush; ex_valid = v.valid; ex_wd = v.wd;
    ex_wreg = v.wreg; ex_wdata = v.wdata; ex_whilo = v.whilo; ex_hi = v.hi;
    ex_lo = v.lo; tmp_i = v.tmp; cnt_i = v.cnt;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_valid"}, mem_valid, 0);
    chk({tag, ".mem_wd"}, mem_wd, 0);
    chk({tag, ".mem_wreg"}, mem_wreg, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_whilo"}, mem_whilo, 0);
    chk({tag, ".mem_hi"}, mem_hi, 0);
    chk({tag, ".mem_lo"}, mem_lo, 0);
    chk({tag, ".tmp_o"}, tmp_o, 0);
    chk({tag, ".cnt_o"}, cnt_o, 0);
    chk({tag, ".bubble_cnt"}, bubble_cnt, 0);
    chk({tag, ".small_bubble_cnt"}, s_bubble_cnt, 0);
    chk({tag, ".small_tmp_o"}, s_tmp_o, 0);
  endtask

  initial begin
    vec_t z;
    z = mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0);
    apply(z);
    rst = 1'b0;
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Advance, invalid gating, loop-back bubbles, downstream holds, flush,
    // ignored stall bits, hold of a live payload, flush during hold.
    vecs.push_back(mk(6'b000000,0,1,9,1,32'hDEADBEEF,1,32'h11111111,32'h22222222,64'h55,3,
                      1,9,1,32'hDEADBEEF,1,32'h11111111,32'h22222222,64'h0,0,0));
    vecs.push_back(mk(6'b000000,0,0,7,1,32'h12345678,1,32'hAAAA0000,32'h0000BBBB,64'h66,1,
                      0,7,0,32'h12345678,0,32'hAAAA0000,32'h0000BBBB,64'h0,0,0));
    vecs.push_back(mk(6'b001000,0,1,3,1,32'hCAFEF00D,1,32'h1,32'h2,64'h1,1,
                      0,0,0,0,0,0,0,64'h1,1,1));
    vecs.push_back(mk(6'b001000,0,1,3,1,32'hCAFEF00D,1,32'h1,32'h2,64'h2,2,
                      0,0,0,0,0,0,0,64'h2,2,2));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(6'b011000,0,1,4,1,32'h0F0F0F0F,1,32'h3,32'h4,64'h9,3,
                        0,0,0,0,0,0,0,64'h2,2,2));
    vecs.push_back(mk(6'b001000,1,1,4,1,32'h0F0F0F0F,1,32'h3,32'h4,64'h7,3,
                      0,0,0,0,0,0,0,64'h0,0,2));
    vecs.push_back(mk(6'b110111,0,1,31,0,32'hFFFFFFFF,1,32'h89ABCDEF,32'h01234567,64'hABC,2,
                      1,31,0,32'hFFFFFFFF,1,32'h89ABCDEF,32'h01234567,64'h0,0,2));
    vecs.push_back(mk(6'b101000,0,1,1,1,32'h1,1,32'h1,32'h1,64'hFFFF_FFFF_FFFF_FFFF,3,
                      0,0,0,0,0,0,0,64'hFFFF_FFFF_FFFF_FFFF,3,3));
    vecs.push_back(mk(6'b000000,0,1,3,1,32'h0BADF00D,0,32'h5,32'h6,64'h1,1,
                      1,3,1,32'h0BADF00D,0,32'h5,32'h6,64'h0,0,3));
    vecs.push_back(mk(6'b011000,0,0,0,0,32'h0,0,32'h0,32'h0,64'h3,3,
                      1,3,1,32'h0BADF00D,0,32'h5,32'h6,64'h0,0,3));
    vecs.push_back(mk(6'b111000,1,1,3,1,32'h0BADF00D,1,32'h5,32'h6,64'h3,3,
                      0,0,0,0,0,0,0,64'h0,0,3));
    vecs.push_back(mk(6'b011000,0,1,8,1,32'h77777777,1,32'h5,32'h6,64'h4,2,
                      0,0,0,0,0,0,0,64'h0,0,3));

    foreach (vecs[i]) begin
      string t;
      logic [15:0] eb_small;
      @(negedge clk);
      apply(vecs[i]);
      @(posedge clk);
      #1;
      t = $sformatf("v%0d", i);
      eb_small = (vecs[i].e_bcnt > 16'd3) ? 16'd3 : vecs[i].e_bcnt;
      chk({t, ".mem_valid"}, mem_valid, vecs[i].e_valid);
      chk({t, ".mem_wd"}, mem_wd, vecs[i].e_wd);
      chk({t, ".mem_wreg"}, mem_wreg, vecs[i].e_wreg);
      chk({t, ".mem_wdata"}, mem_wdata, vecs[i].e_wdata);
      chk({t, ".mem_whilo"}, mem_whilo, vecs[i].e_whilo);
      chk({t, ".mem_hi"}, mem_hi, vecs[i].e_hi);
      chk({t, ".mem_lo"}, mem_lo, vecs[i].e_lo);
      chk({t, ".tmp_o"}, tmp_o, vecs[i].e_tmp);
      chk({t, ".cnt_o"}, cnt_o, vecs[i].e_cnt);
      chk({t, ".bubble_cnt"}, bubble_cnt, vecs[i].e_bcnt);
      chk({t, ".small_bubble_cnt"}, s_bubble_cnt, eb_small);
    end

    // Saturation: fresh counters, five bubbles; 2-bit counter stops at 3.
    @(negedge clk);
    rst = 1'b0;
    apply(z);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stall = 6'b001000; flush = 1'b0;
      tmp_i = 64'(i + 10); cnt_i = 2'(i);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.small_bubble_cnt", i), s_bubble_cnt, (i >= 2) ? 3 : i + 1);
      chk($sformatf("sat%0d.bubble_cnt", i), bubble_cnt, i + 1);
      chk($sformatf("sat%0d.tmp_o", i), tmp_o, i + 10);
      chk($sformatf("sat%0d.cnt_o", i), cnt_o, i & 3);
    end

    // Reset mid multi-cycle op with nonzero inputs: clears without a clock edge.
    @(posedge clk);
    #3;
    stall = 6'($urandom) | 6'b000001; flush = 1'b1; ex_valid = 1'b1; ex_wreg = 1'b1;
    ex_whilo = 1'b1; ex_wd = 5'($urandom) | 5'd1; ex_wdata = $urandom | 32'd1;
    ex_hi = $urandom | 32'd1; ex_lo = $urandom | 32'd1;
    tmp_i = {$urandom, $urandom} | 64'd1; cnt_i = 2'd3;
    rst = 1'b0;
    #1;
    chk_zero("midreset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
